collision_scorer: RTL and testbench
===================================

Name: collision_scorer

Overview:
- Downstream consumer of the two obstacle stages and the dino position stage.
- Each clock, tests the dino bounding box against both obstacle boxes, then confirms a hit over consecutive frames.
- Runs the game state machine (IDLE/RUN/DYING/OVER) and keeps a BCD score and a high score.
- Drives game_rst back to the obstacle and dino stages, and feeds the score digits to the display path.

Parameters:
- DINO_W, 40, dino box width in pixels
- DINO_H, 43, dino box height in pixels
- HIT_FRAMES, 2, consecutive overlapping frames required to register a hit (1..15)
- DEATH_FRAMES, 30, frames spent in DYING before OVER (1..255)
- SCORE_DIV, 6, frames per score increment (1..63)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  debounced start/jump button level
- dino_h  in  10  dino left edge
- dino_v  in  10  dino top edge
- obs0_h, obs1_h  in  10 each  obstacle right edge (reference point is upper-right corner)
- obs0_v, obs1_v  in  10 each  obstacle top edge
- obs0_width, obs1_width  in  8 each  obstacle width
- obs0_height, obs1_height  in  8 each  obstacle height
- running  out  1  high in RUN
- dying  out  1  high in DYING
- game_over  out  1  high in OVER
- game_rst  out  1  one-cycle pulse on entry to RUN
- hit_now  out  1  registered overlap flag (either obstacle)
- score  out  16  4-digit BCD, digit 3 in [15:12]
- high_score  out  16  4-digit BCD

Behaviour:
- Reset values: state IDLE; running, dying, game_over, game_rst, hit_now all 0; score 0x0000; high_score 0x0000; hit and frame counters 0.
- Overlap arithmetic: all in 11 bits, unsigned.
  - obs_left = obs_h - obs_width, clamped to 0 when obs_width > obs_h.
  - Overlap when all four hold: dino_h < obs_h; dino_h + DINO_W > obs_left; dino_v < obs_v + obs_height; dino_v + DINO_H > obs_v.
  - Edges that only touch do not overlap.
- hit_now = OR of the two overlaps, registered: 1-cycle latency from inputs, evaluated every clock in every state.
- State machine: transitions and counters advance only on a frame_tick cycle unless stated otherwise.
  - IDLE: on a rising edge of start (start && !start_q, any cycle) -> RUN.
  - RUN, hit counting: on frame_tick, if hit_now then hit_cnt++ else hit_cnt = 0. When hit_cnt reaches HIT_FRAMES -> DYING, death_cnt = 0.
  - RUN, scoring: div_cnt increments on each frame_tick. When it reaches SCORE_DIV-1 it wraps to 0 and score BCD-increments with digit carry. Score saturates at 0x9999.
  - RUN: start is ignored.
  - DYING: score and div_cnt frozen; death_cnt++ per frame_tick. When death_cnt == DEATH_FRAMES-1 at a frame_tick -> OVER. In the same clock, high_score <= score if score > high_score.
  - OVER: outputs hold. A start rising edge -> RUN.
- Entry to RUN (from IDLE or OVER), all in the same clock:
  - score = 0, hit_cnt = 0, div_cnt = 0.
  - game_rst pulses high for exactly that one clock.
- Simultaneous events:
  - Hit confirmation and a score increment on the same frame_tick: the increment is applied, then the state goes to DYING.
  - A start edge on the clock of a frame_tick in OVER: the start edge wins.
- Reset mid-operation returns to IDLE and clears high_score.

Optional Feature:
- Macro: COLLISION_SCORER_HIGH_SCORE_EN.
- Defined: high_score register kept and updated as above.
- Undefined: no high-score register; high_score output tied to 0x0000; the comparison on entry to OVER is omitted.

Test Plan:
- Reset then start edge -> game_rst high 1 cycle, running=1, score=0x0000; after 12 frame_ticks with no overlap, score=0x0002.
- dino_h=100, dino_v=397 (box 100..140 x 397..440); obs0_h=150, width 30, v 360, height 80 -> hit_now=1 one clock after the inputs settle. obs0_h=100 (touching edge) -> hit_now=0.
- Overlap present on frame 1, absent on frame 2, present on frame 3 with HIT_FRAMES=2 -> stays in RUN. Overlap on 2 consecutive frames -> dying=1.
- From DYING, count DEATH_FRAMES=30 ticks -> game_over=1 on the 30th. With score 0x0123 over high 0x0045, high_score=0x0123. With the macro undefined, high_score=0x0000.
- Preload score 0x9998 via run time, 2 increments -> 0x9999, then holds. Carry check: 0x0099 -> 0x0100.
- In OVER, start edge -> running=1, score=0x0000, high_score retained. Assert rst while in DYING -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/collision_scorer.sv
// -----------------------------------------------------------------------------
// collision_scorer
//
// Purpose:
//   Tests the dino bounding box against two obstacle boxes every clock,
//   confirms a hit over HIT_FRAMES consecutive frames, and runs the game state
//   machine (IDLE / RUN / DYING / OVER). It keeps a 4-digit BCD score and,
//   optionally, a BCD high score. It also drives game_rst back to the obstacle
//   and dino stages.
//
// Optional feature:
//   COLLISION_SCORER_HIGH_SCORE_EN
//     - Defined: the high-score register is kept. On entry to OVER it is
//       updated when the final score beats it.
//     - Undefined: high_score is tied to 0x0000.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   frame_tick     in   one-cycle pulse per video frame
//   start          in   debounced start/jump button level
//   dino_h/dino_v  in   dino left / top edge (10 bits)
//   obsN_h         in   obstacle right edge (upper-right reference point)
//   obsN_v         in   obstacle top edge
//   obsN_width     in   obstacle width (8 bits)
//   obsN_height    in   obstacle height (8 bits)
//   running        out  high in RUN
//   dying          out  high in DYING
//   game_over      out  high in OVER
//   game_rst       out  one-cycle pulse on entry to RUN
//   hit_now        out  registered overlap flag (either obstacle)
//   score          out  4-digit BCD score, digit 3 in [15:12]
//   high_score     out  4-digit BCD high score
// -----------------------------------------------------------------------------
module collision_scorer #(
   parameter int DINO_W       = 40,
   parameter int DINO_H       = 43,
   parameter int HIT_FRAMES   = 2,
   parameter int DEATH_FRAMES = 30,
   parameter int SCORE_DIV    = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        start,
   input  logic [9:0]  dino_h,
   input  logic [9:0]  dino_v,
   input  logic [9:0]  obs0_h,
   input  logic [9:0]  obs0_v,
   input  logic [7:0]  obs0_width,
   input  logic [7:0]  obs0_height,
   input  logic [9:0]  obs1_h,
   input  logic [9:0]  obs1_v,
   input  logic [7:0]  obs1_width,
   input  logic [7:0]  obs1_height,
   output logic        running,
   output logic        dying,
   output logic        game_over,
   output logic        game_rst,
   output logic        hit_now,
   output logic [15:0] score,
   output logic [15:0] high_score
);

   localparam logic [10:0] DW_11      = 11'(DINO_W);
   localparam logic [10:0] DH_11      = 11'(DINO_H);
   localparam logic [3:0]  HIT_LIM    = 4'(HIT_FRAMES);
   localparam logic [5:0]  DIV_LAST   = 6'(SCORE_DIV - 1);
   localparam logic [7:0]  DEATH_LAST = 8'(DEATH_FRAMES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DYING,
      S_OVER
   } state_t;

   // --------------------------------------------------------------------------
   // Box overlap test. All arithmetic is 11-bit unsigned, so right and bottom
   // edges near the 10-bit limit do not wrap. When the width exceeds the right
   // edge, the left edge clamps to 0.
   // Edges that only touch are not an overlap (strict comparisons).
   // --------------------------------------------------------------------------
   function automatic logic box_overlap(
      input logic [10:0] d_left,
      input logic [10:0] d_right,
      input logic [10:0] d_top,
      input logic [10:0] d_bottom,
      input logic [9:0]  o_h,
      input logic [9:0]  o_v,
      input logic [7:0]  o_w,
      input logic [7:0]  o_ht
   );
      logic [10:0] o_right;
      logic [10:0] o_left;
      logic [10:0] o_top;
      logic [10:0] o_bottom;
      o_right  = {1'b0, o_h};
      o_left   = ({3'b000, o_w} > o_right) ? 11'd0 : (o_right - {3'b000, o_w});
      o_top    = {1'b0, o_v};
      o_bottom = o_top + {3'b000, o_ht};
      return (d_left < o_right) && (d_right > o_left) &&
             (d_top < o_bottom) && (d_bottom > o_top);
   endfunction

   // --------------------------------------------------------------------------
   // BCD increment with per-digit carry. The value saturates at 9999.
   // --------------------------------------------------------------------------
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   // Dino box edges.
   logic [10:0] dino_left;
   logic [10:0] dino_right;
   logic [10:0] dino_top;
   logic [10:0] dino_bottom;
   logic        overlap_p0;

   assign dino_left   = {1'b0, dino_h};
   assign dino_right  = {1'b0, dino_h} + DW_11;
   assign dino_top    = {1'b0, dino_v};
   assign dino_bottom = {1'b0, dino_v} + DH_11;

   assign overlap_p0 =
      box_overlap(dino_left, dino_right, dino_top, dino_bottom,
                  obs0_h, obs0_v, obs0_width, obs0_height) ||
      box_overlap(dino_left, dino_right, dino_top, dino_bottom,
                  obs1_h, obs1_v, obs1_width, obs1_height);

   // ---- stage p0 -> p1: registered overlap flag, evaluated in every state ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_now <= 1'b0;
      end else begin
         hit_now <= overlap_p0;
      end
   end

   // Game state and counters.
   state_t      state;
   state_t      state_n;
   logic        start_q;
   logic        start_edge;
   logic [15:0] score_r;
   logic [15:0] score_n;
   logic [3:0]  hit_cnt;
   logic [3:0]  hit_cnt_n;
   logic [5:0]  div_cnt;
   logic [5:0]  div_cnt_n;
   logic [7:0]  death_cnt;
   logic [7:0]  death_cnt_n;
   logic        game_rst_n;

   assign start_edge = start && !start_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         start_q   <= 1'b0;
         score_r   <= 16'h0000;
         hit_cnt   <= 4'd0;
         div_cnt   <= 6'd0;
         death_cnt <= 8'd0;
         game_rst  <= 1'b0;
      end else begin
         state     <= state_n;
         start_q   <= start;
         score_r   <= score_n;
         hit_cnt   <= hit_cnt_n;
         div_cnt   <= div_cnt_n;
         death_cnt <= death_cnt_n;
         game_rst  <= game_rst_n;
      end
   end

   always_comb begin
      state_n     = state;
      score_n     = score_r;
      hit_cnt_n   = hit_cnt;
      div_cnt_n   = div_cnt;
      death_cnt_n = death_cnt;
      game_rst_n  = 1'b0;

      case (state)
         S_IDLE, S_OVER: begin
            // In OVER, a start edge takes priority over anything a frame_tick
            // in the same clock would do. OVER has no tick action anyway.
            if (start_edge) begin
               state_n    = S_RUN;
               score_n    = 16'h0000;
               hit_cnt_n  = 4'd0;
               div_cnt_n  = 6'd0;
               game_rst_n = 1'b1;
            end
         end

         S_RUN: begin
            if (frame_tick) begin
               // Scoring still applies on the frame that confirms the hit.
               if (div_cnt == DIV_LAST) begin
                  div_cnt_n = 6'd0;
                  score_n   = bcd_inc(score_r);
               end else begin
                  div_cnt_n = div_cnt + 6'd1;
               end

               if (hit_now) begin
                  hit_cnt_n = hit_cnt + 4'd1;
                  if ((hit_cnt + 4'd1) == HIT_LIM) begin
                     state_n     = S_DYING;
                     death_cnt_n = 8'd0;
                  end
               end else begin
                  hit_cnt_n = 4'd0;
               end
            end
         end

         S_DYING: begin
            if (frame_tick) begin
               if (death_cnt == DEATH_LAST) begin
                  state_n = S_OVER;
               end else begin
                  death_cnt_n = death_cnt + 8'd1;
               end
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign running   = (state == S_RUN);
   assign dying     = (state == S_DYING);
   assign game_over = (state == S_OVER);
   assign score     = score_r;

`ifdef COLLISION_SCORER_HIGH_SCORE_EN
   // The score is frozen in DYING, so the value compared here is the final
   // score. A plain unsigned compare of packed BCD matches the decimal order.
   logic [15:0] high_r;
   logic        over_entry;

   assign over_entry = (state == S_DYING) && frame_tick && (death_cnt == DEATH_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         high_r <= 16'h0000;
      end else if (over_entry && (score_r > high_r)) begin
         high_r <= score_r;
      end
   end

   assign high_score = high_r;
`else
   assign high_score = 16'h0000;
`endif

endmodule

// File: tb/tb_collision_scorer.sv
module tb_collision_scorer;

   localparam int DINO_W       = 40;
   localparam int DINO_H       = 43;
   localparam int HIT_FRAMES   = 2;
   localparam int DEATH_FRAMES = 30;
   localparam int SCORE_DIV    = 6;

`ifdef COLLISION_SCORER_HIGH_SCORE_EN
   localparam bit HS_EN = 1'b1;
`else
   localparam bit HS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic        start;
   logic [9:0]  dino_h, dino_v;
   logic [9:0]  obs0_h, obs0_v, obs1_h, obs1_v;
   logic [7:0]  obs0_width, obs0_height, obs1_width, obs1_height;
   logic        running, dying, game_over, game_rst, hit_now;
   logic [15:0] score, high_score;

   int n_checks = 0;
   int n_errors = 0;

   collision_scorer #(
      .DINO_W(DINO_W), .DINO_H(DINO_H), .HIT_FRAMES(HIT_FRAMES),
      .DEATH_FRAMES(DEATH_FRAMES), .SCORE_DIV(SCORE_DIV)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .dino_h(dino_h), .dino_v(dino_v),
      .obs0_h(obs0_h), .obs0_v(obs0_v), .obs0_width(obs0_width), .obs0_height(obs0_height),
      .obs1_h(obs1_h), .obs1_v(obs1_v), .obs1_width(obs1_width), .obs1_height(obs1_height),
      .running(running), .dying(dying), .game_over(game_over), .game_rst(game_rst),
      .hit_now(hit_now), .score(score), .high_score(high_score)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (game-level abstraction) ----------------
   localparam int PH_IDLE = 0, PH_RUN = 1, PH_DYING = 2, PH_OVER = 3;
   int m_phase, m_score, m_high, m_streak, m_frames, m_dying_frames;
   bit m_hit, m_start_q, m_grst;

   function automatic bit boxes_touch(input int dh, input int dv, input int oh,
                                      input int ow, input int ov, input int oht);
      int left;
      left = oh - ow;
      if (left < 0) left = 0;
      return (dh < oh) && (dh + DINO_W > left) && (dv < ov + oht) && (dv + DINO_H > ov);
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      return 16'(((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + (n % 10));
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE; m_score = 0; m_high = 0; m_streak = 0; m_frames = 0;
      m_dying_frames = 0; m_hit = 0; m_start_q = 0; m_grst = 0;
   endtask

   task automatic model_clock();
      bit nh, sedge;
      nh = boxes_touch(int'(dino_h), int'(dino_v), int'(obs0_h), int'(obs0_width), int'(obs0_v), int'(obs0_height)) ||
           boxes_touch(int'(dino_h), int'(dino_v), int'(obs1_h), int'(obs1_width), int'(obs1_v), int'(obs1_height));
      sedge = start && !m_start_q;
      m_grst = 0;
      if ((m_phase == PH_IDLE || m_phase == PH_OVER) && sedge) begin
         m_phase = PH_RUN; m_score = 0; m_streak = 0; m_frames = 0; m_grst = 1;
      end else if (m_phase == PH_RUN && frame_tick) begin
         m_frames++;
         if (m_frames == SCORE_DIV) begin
            m_frames = 0;
            if (m_score < 9999) m_score++;
         end
         m_streak = m_hit ? m_streak + 1 : 0;
         if (m_streak == HIT_FRAMES) begin
            m_phase = PH_DYING; m_dying_frames = 0;
         end
      end else if (m_phase == PH_DYING && frame_tick) begin
         m_dying_frames++;
         if (m_dying_frames == DEATH_FRAMES) begin
            m_phase = PH_OVER;
            if (HS_EN && m_score > m_high) m_high = m_score;
         end
      end
      m_start_q = start;
      m_hit = nh;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check1("m_running", running, m_phase == PH_RUN);
      check1("m_dying", dying, m_phase == PH_DYING);
      check1("m_game_over", game_over, m_phase == PH_OVER);
      check1("m_game_rst", game_rst, m_grst);
      check1("m_hit_now", hit_now, m_hit);
      check16("m_score", score, to_bcd(m_score));
      check16("m_high_score", high_score, to_bcd(m_high));
   endtask

   // Inputs are set between steps (after a negedge); outputs are checked at negedge.
   task automatic step();
      @(posedge clk);
      if (rst) model_reset(); else model_clock();
      @(negedge clk);
      compare_model();
   endtask

   task automatic tick1();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
   endtask

   task automatic tick_n(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1; step(); frame_tick = 1'b0;
         for (int j = 0; j < gap; j++) step();
      end
   endtask

   task automatic park();
      obs0_h = 10'd0; obs0_v = 10'd0; obs0_width = 8'd0; obs0_height = 8'd0;
      obs1_h = 10'd0; obs1_v = 10'd0; obs1_width = 8'd0; obs1_height = 8'd0;
   endtask

   task automatic set_hit0();
      dino_h = 10'd100; dino_v = 10'd397;
      obs0_h = 10'd150; obs0_width = 8'd30; obs0_v = 10'd360; obs0_height = 8'd80;
   endtask

   task automatic start_edge();
      start = 1'b1; step(); start = 1'b0;
   endtask

   typedef struct {
      int dh; int dv; int oh; int ow; int ov; int oht; bit sel; bit exp;
   } ov_vec_t;

   ov_vec_t tbl[12];

   initial begin
      rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
      dino_h = 10'd100; dino_v = 10'd397;
      park();
      model_reset();

      tbl[0]  = '{100, 397, 150,  30,  360, 80, 1'b0, 1'b1};
      tbl[1]  = '{100, 397, 100,  30,  360, 80, 1'b0, 1'b0};
      tbl[2]  = '{100, 397, 170,  30,  360, 80, 1'b0, 1'b0};
      tbl[3]  = '{100, 397, 169,  30,  360, 80, 1'b0, 1'b1};
      tbl[4]  = '{100, 397, 150,  30,  440, 80, 1'b0, 1'b0};
      tbl[5]  = '{100, 397, 150,  30,  300, 97, 1'b0, 1'b0};
      tbl[6]  = '{100, 397, 150,  30,  300, 98, 1'b0, 1'b1};
      tbl[7]  = '{0,   397, 20,   200, 360, 80, 1'b0, 1'b1};
      tbl[8]  = '{500, 1000, 520, 30, 1010, 20, 1'b0, 1'b1};
      tbl[9]  = '{100, 397, 150,  30,  360, 80, 1'b1, 1'b1};
      tbl[10] = '{100, 397, 101,  1,   360, 80, 1'b1, 1'b1};
      tbl[11] = '{100, 397, 141,  1,   360, 80, 1'b1, 1'b0};

      // Reset values.
      repeat (3) @(negedge clk);
      check1("rst_running", running, 1'b0);
      check1("rst_dying", dying, 1'b0);
      check1("rst_game_over", game_over, 1'b0);
      check1("rst_game_rst", game_rst, 1'b0);
      check1("rst_hit_now", hit_now, 1'b0);
      check16("rst_score", score, 16'h0000);
      check16("rst_high", high_score, 16'h0000);
      rst = 1'b0;

      // Overlap vectors, one clock of latency, applied in IDLE.
      for (int i = 0; i < 12; i++) begin
         park();
         dino_h = 10'(tbl[i].dh); dino_v = 10'(tbl[i].dv);
         if (!tbl[i].sel) begin
            obs0_h = 10'(tbl[i].oh); obs0_width = 8'(tbl[i].ow);
            obs0_v = 10'(tbl[i].ov); obs0_height = 8'(tbl[i].oht);
         end else begin
            obs1_h = 10'(tbl[i].oh); obs1_width = 8'(tbl[i].ow);
            obs1_v = 10'(tbl[i].ov); obs1_height = 8'(tbl[i].oht);
         end
         step();
         check1($sformatf("overlap_vec%0d", i), hit_now, tbl[i].exp);
      end
      park(); dino_h = 10'd100; dino_v = 10'd397;
      step();

      // Game 1: start, score, broken then confirmed hit, death sequence.
      start_edge();
      check1("g1_game_rst", game_rst, 1'b1);
      check1("g1_running", running, 1'b1);
      check16("g1_score0", score, 16'h0000);
      step();
      check1("g1_game_rst_off", game_rst, 1'b0);
      tick_n(12, 1);
      check16("g1_score_12ticks", score, 16'h0002);
      set_hit0(); step(); tick1();
      park(); step(); tick1();
      set_hit0(); step(); tick1();
      check1("g1_broken_hit_run", running, 1'b1);
      check1("g1_broken_hit_dying", dying, 1'b0);
      tick1();
      check1("g1_confirm_dying", dying, 1'b1);
      park();
      tick_n(DEATH_FRAMES - 1, 1);
      check1("g1_not_over_yet", game_over, 1'b0);
      tick1();
      check1("g1_over", game_over, 1'b1);
      check16("g1_high", high_score, HS_EN ? 16'h0002 : 16'h0000);

      // Game 2: start edge coinciding with a frame_tick in OVER.
      start = 1'b1; frame_tick = 1'b1; step(); start = 1'b0; frame_tick = 1'b0;
      check1("g2_restart_running", running, 1'b1);
      check1("g2_restart_game_rst", game_rst, 1'b1);
      check16("g2_restart_score", score, 16'h0000);
      check16("g2_high_kept", high_score, HS_EN ? 16'h0002 : 16'h0000);
      tick_n(270, 0);
      check16("g2_score45", score, 16'h0045);
      set_hit0(); step(); tick1(); tick1();
      check1("g2_dying", dying, 1'b1);
      park();
      tick_n(DEATH_FRAMES, 0);
      check1("g2_over", game_over, 1'b1);
      check16("g2_high", high_score, HS_EN ? 16'h0045 : 16'h0000);

      // Game 3: BCD carry, hit confirmed on a score-increment frame.
      start_edge(); step();
      tick_n(594, 0);
      check16("g3_score99", score, 16'h0099);
      tick_n(6, 0);
      check16("g3_carry100", score, 16'h0100);
      tick_n(136, 0);
      check16("g3_score122", score, 16'h0122);
      set_hit0(); step(); tick1(); tick1();
      check1("g3_simul_dying", dying, 1'b1);
      check16("g3_simul_score", score, 16'h0123);
      park();
      tick_n(DEATH_FRAMES, 0);
      check1("g3_over", game_over, 1'b1);
      check16("g3_high", high_score, HS_EN ? 16'h0123 : 16'h0000);

      // Game 4: saturation at 9999, then asynchronous reset in DYING.
      start_edge(); step();
      check16("g4_high_retained", high_score, HS_EN ? 16'h0123 : 16'h0000);
      tick_n(59988, 0);
      check16("g4_score9998", score, 16'h9998);
      tick_n(6, 0);
      check16("g4_score9999", score, 16'h9999);
      tick_n(12, 0);
      check16("g4_score_sat", score, 16'h9999);
      set_hit0(); step(); tick1(); tick1();
      check1("g4_dying", dying, 1'b1);
      tick_n(5, 0);
      #2 rst = 1'b1;
      #1;
      check1("arst_running", running, 1'b0);
      check1("arst_dying", dying, 1'b0);
      check1("arst_game_over", game_over, 1'b0);
      check1("arst_game_rst", game_rst, 1'b0);
      check1("arst_hit_now", hit_now, 1'b0);
      check16("arst_score", score, 16'h0000);
      check16("arst_high", high_score, 16'h0000);
      model_reset();
      @(negedge clk);
      step();
      rst = 1'b0;
      park();
      step();

      // Randomized play against the model.
      for (int i = 0; i < 3000; i++) begin
         frame_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) start = ~start;
         dino_h = 10'($urandom_range(60, 140));
         dino_v = 10'($urandom_range(350, 420));
         if ($urandom_range(0, 1) == 0) begin
            obs0_h = 10'(int'(dino_h) + $urandom_range(0, 90));
            obs0_width = 8'($urandom_range(0, 120));
            obs0_v = 10'($urandom_range(300, 480));
            obs0_height = 8'($urandom_range(0, 100));
         end else begin
            obs0_h = 10'($urandom_range(0, 1023));
            obs0_width = 8'($urandom_range(0, 255));
            obs0_v = 10'($urandom_range(0, 1023));
            obs0_height = 8'($urandom_range(0, 255));
         end
         obs1_h = 10'($urandom_range(0, 1023));
         obs1_width = 8'($urandom_range(0, 255));
         obs1_v = 10'($urandom_range(0, 1023));
         obs1_height = 8'($urandom_range(0, 255));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
